// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU core control slice.
//   - tpu_state_e : sequencer phase encoding (also used by debug/SPI status readback)
//   - MOVE_W_DEF, MAX_MOVES_DEF : default move width and move-count saturation limit
//   - tpu_move_t  : move descriptor {undo, data}
package tpu_pkg;

    localparam int MOVE_W_DEF    = 9;
    localparam int MAX_MOVES_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_INPUT_GRID_MOVE = 3'd1,
        ST_COMPUTE_GRID    = 3'd2,
        ST_COMPUTE_DNN     = 3'd3,
        ST_STORE_OUTPUT    = 3'd4,
        ST_SEND_OUTPUT     = 3'd5
    } tpu_state_e;

    typedef struct packed {
        logic                  undo;
        logic [MOVE_W_DEF-1:0] data;
    } tpu_move_t;

endpackage

// File: rtl/tpu_phase_wdog.sv
// Per-phase watchdog for tpu_seq_ctrl (only instantiated when TPU_SEQ_WDOG_EN
// is defined).
//   clk, nrst : clock, asynchronous active-low reset
//   clr       : phase is changing this cycle; counter restarts from 0
//   active    : sequencer is in a non-idle phase; counter advances
//   fire      : phase has lasted WDOG_CYC cycles; abort it at the next edge
module tpu_phase_wdog #(
    parameter int WDOG_CYC = 4096
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic active,
    output logic fire
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)         cnt_d = '0;
        else if (active) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // cnt_q is 0 in the first cycle of a phase, so matching WDOG_CYC-1 makes
    // the abort edge land exactly WDOG_CYC cycles after the phase was entered.
    assign fire = active && (cnt_q == 16'(WDOG_CYC - 1));

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Top-level phase sequencer for the TPU core.
// Accepts place/undo moves from the SPI front end, hands them to the grid
// engine, then runs grid -> DNN -> store -> send with start/done handshakes.
// Owns the global move counter.
//
// Ports:
//   clk, nrst                         clock, asynchronous active-low reset
//   mv_valid/mv_ready/mv_undo/mv_data move input from SPI front end
//   eval_req                          evaluate without a new move (sampled in IDLE)
//   gmv_valid/gmv_ready/gmv_undo/gmv_data  move handed to grid engine
//   *_start / *_done                  per-engine one-cycle start / done pulses
//   move_cnt                          current move count (saturating, never wraps)
//   busy                              sequencer not idle
//   mv_reject                         move consumed but refused (one-cycle pulse)
//   err                               sticky watchdog error
//
// Optional feature: define TPU_SEQ_WDOG_EN to add a per-phase watchdog that
// aborts any phase lasting WDOG_CYC cycles and sets err. Without it, err is
// tied 0 and phases wait indefinitely.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int MOVE_W    = MOVE_W_DEF,
    parameter int MAX_MOVES = MAX_MOVES_DEF,
    parameter int WDOG_CYC  = 4096
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic              mv_undo,
    input  logic [MOVE_W-1:0] mv_data,
    input  logic              eval_req,
    output logic              gmv_valid,
    input  logic              gmv_ready,
    output logic              gmv_undo,
    output logic [MOVE_W-1:0] gmv_data,
    output logic              grid_start,
    output logic              dnn_start,
    output logic              store_start,
    output logic              send_start,
    input  logic              grid_done,
    input  logic              dnn_done,
    input  logic              store_done,
    input  logic              send_done,
    output logic [7:0]        move_cnt,
    output logic              busy,
    output logic              mv_reject,
    output logic              err
);

    tpu_state_e        state_q, state_d;
    logic [7:0]        move_cnt_q, move_cnt_d;
    logic              mv_ready_q, mv_ready_d;
    logic              gmv_valid_q, gmv_valid_d;
    logic              gmv_undo_q, gmv_undo_d;
    logic [MOVE_W-1:0] gmv_data_q, gmv_data_d;
    logic              grid_start_q, grid_start_d;
    logic              dnn_start_q, dnn_start_d;
    logic              store_start_q, store_start_d;
    logic              send_start_q, send_start_d;
    logic              mv_reject_q, mv_reject_d;

    logic mv_acc, mv_refuse, phase_chg, wdog_fire;

    // mv_ready_q is only ever high in IDLE, so it doubles as the IDLE qualifier.
    assign mv_acc    = mv_valid && mv_ready_q;
    assign mv_refuse = mv_undo ? (move_cnt_q == 8'd0)
                               : (move_cnt_q == 8'(MAX_MOVES));

    always_comb begin
        state_d     = state_q;
        move_cnt_d  = move_cnt_q;
        gmv_undo_d  = gmv_undo_q;
        gmv_data_d  = gmv_data_q;
        mv_reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mv_acc) begin
                    if (mv_refuse) begin
                        mv_reject_d = 1'b1;
                    end else begin
                        gmv_undo_d = mv_undo;
                        gmv_data_d = mv_data;
                        state_d    = ST_INPUT_GRID_MOVE;
                    end
                end else if (eval_req) begin
                    state_d = ST_COMPUTE_DNN;
                end
            end
            ST_INPUT_GRID_MOVE: begin
                if (gmv_valid_q && gmv_ready) begin
                    move_cnt_d = gmv_undo_q ? move_cnt_q - 8'd1 : move_cnt_q + 8'd1;
                    state_d    = ST_COMPUTE_GRID;
                end
            end
            // A done that coincides with the start pulse belongs to a previous
            // request, so done is only honoured once start has dropped.
            ST_COMPUTE_GRID: if (grid_done  && !grid_start_q)  state_d = ST_COMPUTE_DNN;
            ST_COMPUTE_DNN:  if (dnn_done   && !dnn_start_q)   state_d = ST_STORE_OUTPUT;
            ST_STORE_OUTPUT: if (store_done && !store_start_q) state_d = ST_SEND_OUTPUT;
            ST_SEND_OUTPUT:  if (send_done  && !send_start_q)  state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        // Watchdog abort wins over everything, including the move count update.
        if (wdog_fire) begin
            state_d    = ST_IDLE;
            move_cnt_d = move_cnt_q;
        end

        phase_chg = (state_d != state_q);

        // Outputs are registered off the next state so they line up with it.
        mv_ready_d    = (state_d == ST_IDLE);
        gmv_valid_d   = (state_d == ST_INPUT_GRID_MOVE);
        grid_start_d  = (state_d == ST_COMPUTE_GRID) && (state_q != ST_COMPUTE_GRID);
        dnn_start_d   = (state_d == ST_COMPUTE_DNN)  && (state_q != ST_COMPUTE_DNN);
        store_start_d = (state_d == ST_STORE_OUTPUT) && (state_q != ST_STORE_OUTPUT);
        send_start_d  = (state_d == ST_SEND_OUTPUT)  && (state_q != ST_SEND_OUTPUT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            move_cnt_q    <= '0;
            mv_ready_q    <= 1'b0;
            gmv_valid_q   <= 1'b0;
            gmv_undo_q    <= 1'b0;
            gmv_data_q    <= '0;
            grid_start_q  <= 1'b0;
            dnn_start_q   <= 1'b0;
            store_start_q <= 1'b0;
            send_start_q  <= 1'b0;
            mv_reject_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            move_cnt_q    <= move_cnt_d;
            mv_ready_q    <= mv_ready_d;
            gmv_valid_q   <= gmv_valid_d;
            gmv_undo_q    <= gmv_undo_d;
            gmv_data_q    <= gmv_data_d;
            grid_start_q  <= grid_start_d;
            dnn_start_q   <= dnn_start_d;
            store_start_q <= store_start_d;
            send_start_q  <= send_start_d;
            mv_reject_q   <= mv_reject_d;
        end
    end

`ifdef TPU_SEQ_WDOG_EN
    logic err_q, err_d;

    tpu_phase_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (phase_chg),
        .active (state_q != ST_IDLE),
        .fire   (wdog_fire)
    );

    assign err_d = err_q | wdog_fire;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_phase_chg;
    assign unused_phase_chg = phase_chg;
    assign wdog_fire        = 1'b0;
    assign err              = 1'b0;
`endif

    assign mv_ready    = mv_ready_q;
    assign gmv_valid   = gmv_valid_q;
    assign gmv_undo    = gmv_undo_q;
    assign gmv_data    = gmv_data_q;
    assign grid_start  = grid_start_q;
    assign dnn_start   = dnn_start_q;
    assign store_start = store_start_q;
    assign send_start  = send_start_q;
    assign move_cnt    = move_cnt_q;
    assign busy        = (state_q != ST_IDLE);
    assign mv_reject   = mv_reject_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl. WDOG_CYC is overridden to 16; the watchdog
// step is compiled in only when TPU_SEQ_WDOG_EN is defined, otherwise the
// same step checks that a withheld done stalls the phase indefinitely.
module tb_tpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       mv_valid, mv_ready, mv_undo;
    logic [8:0] mv_data;
    logic       eval_req;
    logic       gmv_valid, gmv_ready, gmv_undo;
    logic [8:0] gmv_data;
    logic       grid_start, dnn_start, store_start, send_start;
    logic       grid_done, dnn_done, store_done, send_done;
    logic [7:0] move_cnt;
    logic       busy, mv_reject, err;
    logic [3:0] starts;

    int checks = 0;
    int errors = 0;

    assign starts = {grid_start, dnn_start, store_start, send_start};

    always #5 clk = ~clk;

    tpu_seq_ctrl #(
        .MOVE_W    (9),
        .MAX_MOVES (255),
        .WDOG_CYC  (16)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .mv_valid    (mv_valid),
        .mv_ready    (mv_ready),
        .mv_undo     (mv_undo),
        .mv_data     (mv_data),
        .eval_req    (eval_req),
        .gmv_valid   (gmv_valid),
        .gmv_ready   (gmv_ready),
        .gmv_undo    (gmv_undo),
        .gmv_data    (gmv_data),
        .grid_start  (grid_start),
        .dnn_start   (dnn_start),
        .store_start (store_start),
        .send_start  (send_start),
        .grid_done   (grid_done),
        .dnn_done    (dnn_done),
        .store_done  (store_done),
        .send_done   (send_done),
        .move_cnt    (move_cnt),
        .busy        (busy),
        .mv_reject   (mv_reject),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input int p, input logic v);
        case (p)
            0: grid_done  = v;
            1: dnn_done   = v;
            2: store_done = v;
            default: send_done = v;
        endcase
    endtask

    // Entered with the start of phase 'first' visible; each done is returned
    // three cycles after its start.
    task automatic run_phases(input int first, input bit chk_on);
        for (int p = first; p < 4; p++) begin
            logic [3:0] exp_s;
            exp_s = 4'b1000 >> p;
            if (chk_on) chk($sformatf("start_p%0d", p), 32'(starts), 32'(exp_s));
            tick();
            if (chk_on) chk($sformatf("start_1cyc_p%0d", p), 32'(starts), 32'd0);
            tick();
            tick();
            set_done(p, 1'b1);
            tick();
            set_done(p, 1'b0);
        end
        if (chk_on) begin
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_mv_ready", 32'(mv_ready), 32'd1);
        end
    endtask

    task automatic move_txn(input logic undo, input logic [8:0] data, input logic ev,
                            input bit chk_on, input logic [7:0] exp_cnt);
        mv_valid = 1'b1;
        mv_undo  = undo;
        mv_data  = data;
        eval_req = ev;
        tick();
        mv_valid = 1'b0;
        eval_req = 1'b0;
        if (chk_on) begin
            chk("gmv_valid", 32'(gmv_valid), 32'd1);
            chk("gmv_data", 32'(gmv_data), 32'(data));
            chk("gmv_undo", 32'(gmv_undo), 32'(undo));
            chk("in_mv_ready", 32'(mv_ready), 32'd0);
            chk("in_busy", 32'(busy), 32'd1);
            chk("in_starts", 32'(starts), 32'd0);
        end
        gmv_ready = 1'b1;
        tick();
        gmv_ready = 1'b0;
        if (chk_on) begin
            chk("move_cnt", 32'(move_cnt), 32'(exp_cnt));
            chk("gmv_valid_drop", 32'(gmv_valid), 32'd0);
        end
        run_phases(0, chk_on);
    endtask

    initial begin
        nrst      = 1'b0;
        mv_valid  = 1'b0;
        mv_undo   = 1'b0;
        mv_data   = '0;
        eval_req  = 1'b0;
        gmv_ready = 1'b0;
        grid_done = 1'b0;
        dnn_done  = 1'b0;
        store_done = 1'b0;
        send_done = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_move_cnt", 32'(move_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gmv_valid", 32'(gmv_valid), 32'd0);
        chk("rst_gmv_data", 32'(gmv_data), 32'd0);
        chk("rst_starts", 32'(starts), 32'd0);
        chk("rst_mv_reject", 32'(mv_reject), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        chk("rst_mv_ready", 32'(mv_ready), 32'd1);

        // Place 0x03C through the full pipeline.
        move_txn(1'b0, 9'h03C, 1'b0, 1'b1, 8'd1);

        // Undo back to 0, then an undo at 0 must be refused.
        move_txn(1'b1, 9'h03C, 1'b0, 1'b1, 8'd0);
        mv_valid = 1'b1;
        mv_undo  = 1'b1;
        tick();
        mv_valid = 1'b0;
        chk("undo0_reject", 32'(mv_reject), 32'd1);
        chk("undo0_busy", 32'(busy), 32'd0);
        chk("undo0_cnt", 32'(move_cnt), 32'd0);
        chk("undo0_gmv_valid", 32'(gmv_valid), 32'd0);
        tick();
        chk("undo0_reject_1cyc", 32'(mv_reject), 32'd0);
        chk("undo0_starts", 32'(starts), 32'd0);
        chk("undo0_mv_ready", 32'(mv_ready), 32'd1);

        // Fill to saturation, then a refused 256th place, then an undo.
        for (int i = 0; i < 255; i++) move_txn(1'b0, 9'(i), 1'b0, 1'b0, 8'd0);
        chk("sat_cnt", 32'(move_cnt), 32'd255);
        mv_valid = 1'b1;
        mv_undo  = 1'b0;
        tick();
        mv_valid = 1'b0;
        chk("sat_reject", 32'(mv_reject), 32'd1);
        chk("sat_busy", 32'(busy), 32'd0);
        chk("sat_cnt_hold", 32'(move_cnt), 32'd255);
        tick();
        move_txn(1'b1, 9'h000, 1'b0, 1'b1, 8'd254);

        // Move and eval_req together: the move wins, nothing extra follows.
        move_txn(1'b0, 9'h001, 1'b1, 1'b1, 8'd255);
        repeat (3) tick();
        chk("ev_idle_busy", 32'(busy), 32'd0);
        chk("ev_idle_starts", 32'(starts), 32'd0);

        // Spurious dones: grid_done with grid_start, dnn_done during GRID.
        mv_valid = 1'b1;
        mv_undo  = 1'b1;
        mv_data  = 9'h155;
        tick();
        mv_valid  = 1'b0;
        gmv_ready = 1'b1;
        tick();
        gmv_ready = 1'b0;
        chk("sp_grid_start", 32'(starts), 32'b1000);
        grid_done = 1'b1;
        tick();
        grid_done = 1'b0;
        chk("sp_coincident_done", 32'(starts), 32'd0);
        chk("sp_busy", 32'(busy), 32'd1);
        dnn_done = 1'b1;
        tick();
        dnn_done = 1'b0;
        chk("sp_dnn_in_grid", 32'(starts), 32'd0);
        tick();
        chk("sp_still_waiting", 32'(starts), 32'd0);
        grid_done = 1'b1;
        tick();
        grid_done = 1'b0;
        run_phases(1, 1'b1);
        chk("sp_cnt", 32'(move_cnt), 32'd254);

        // Asynchronous reset during COMPUTE_DNN.
        eval_req = 1'b1;
        tick();
        eval_req = 1'b0;
        chk("ar_dnn_start", 32'(starts), 32'b0100);
        tick();
        #2;
        nrst = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cnt", 32'(move_cnt), 32'd0);
        chk("ar_starts", 32'(starts), 32'd0);
        chk("ar_gmv_valid", 32'(gmv_valid), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        tick();
        chk("ar_mv_ready", 32'(mv_ready), 32'd1);

        // Withhold store_done.
        eval_req = 1'b1;
        tick();
        eval_req = 1'b0;
        tick();
        tick();
        tick();
        dnn_done = 1'b1;
        tick();
        dnn_done = 1'b0;
        chk("wd_store_start", 32'(starts), 32'b0010);
`ifdef TPU_SEQ_WDOG_EN
        repeat (15) tick();
        chk("wd_busy_15", 32'(busy), 32'd1);
        chk("wd_err_15", 32'(err), 32'd0);
        tick();
        chk("wd_busy_16", 32'(busy), 32'd0);
        chk("wd_err_16", 32'(err), 32'd1);
        chk("wd_mv_ready", 32'(mv_ready), 32'd1);
        repeat (3) tick();
        chk("wd_err_sticky", 32'(err), 32'd1);
`else
        repeat (40) tick();
        chk("nowd_busy", 32'(busy), 32'd1);
        chk("nowd_err", 32'(err), 32'd0);
        chk("nowd_starts", 32'(starts), 32'd0);
        store_done = 1'b1;
        tick();
        store_done = 1'b0;
        run_phases(3, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
